// File: rtl/ama_riscv_pkg.sv
// ama_riscv_pkg: shared types for the unified-memory arbiter and its in-flight ID queue.
package ama_riscv_pkg;
  typedef enum logic {ARB_IMEM = 1'b0, ARB_DMEM = 1'b1} arb_id_t;
  typedef struct packed {
    arb_id_t id;
    logic    discard;
  } arb_qentry_t;
endpackage

// File: rtl/ama_riscv_arb_idq.sv
// ama_riscv_arb_idq: ordered queue of in-flight read owners with bulk discard-by-id and empty bypass.
module ama_riscv_arb_idq
  import ama_riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  arb_id_t     push_id,
  input  logic        pop,
  input  logic        flush,
  input  arb_id_t     flush_id,
  output arb_qentry_t head,
  output logic        head_valid,
  output logic        full,
  output logic        empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  arb_qentry_t   q [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty      = count == '0;
  assign full       = count == CW'(DEPTH);
  assign head_valid = !empty || push;
  // A flush also kills the head being popped this cycle; a bypassed push is never flushed.
  always_comb begin
    head         = empty ? arb_qentry_t'{push_id, 1'b0} : q[rptr];
    head.discard = head.discard | (!empty && flush && head.id == flush_id);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= arb_qentry_t'{ARB_IMEM, 1'b0};
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush && q[i].id == flush_id) q[i].discard <= 1'b1;
      if (push) q[wptr] <= arb_qentry_t'{push_id, 1'b0};
      if (push) wptr <= nxt(wptr);
      if (pop) rptr <= nxt(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/ama_riscv_mem_arb.sv
// ama_riscv_mem_arb: shares one memory port between fetch and load/store, routing in-order responses.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed DMEM priority.
module ama_riscv_mem_arb
  import ama_riscv_pkg::*;
#(
  parameter int OUTST = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_req_valid,
  output logic          imem_req_ready,
  input  logic [AW-1:0] imem_req_addr,
  output logic          imem_rsp_valid,
  input  logic          imem_rsp_ready,
  output logic [31:0]   imem_rsp_data,
  input  logic          dmem_req_valid,
  output logic          dmem_req_ready,
  input  logic [AW-1:0] dmem_req_addr,
  input  logic [31:0]   dmem_req_wdata,
  input  logic [3:0]    dmem_req_wmask,
  output logic          dmem_rsp_valid,
  input  logic          dmem_rsp_ready,
  output logic [31:0]   dmem_rsp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic [31:0]   mem_req_wdata,
  output logic [3:0]    mem_req_wmask,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic [31:0]   mem_rsp_data,
  input  logic          flush_imem,
  output logic          err_unexp_rsp
);
  logic        lock, d_wr, i_ok, d_ok, xfer, push, pop, full, empty, head_valid, rsp_live;
  arb_id_t     lock_id, gnt;
  arb_qentry_t head;
`ifdef MEM_ARB_RR_EN
  arb_id_t     last_grant;
`endif
  assign d_wr = |dmem_req_wmask;
  assign i_ok = imem_req_valid && !full;
  assign d_ok = dmem_req_valid && (d_wr || !full);
`ifdef MEM_ARB_RR_EN
  assign gnt = lock ? lock_id :
               (i_ok && d_ok) ? (last_grant == ARB_IMEM ? ARB_DMEM : ARB_IMEM) :
               d_ok ? ARB_DMEM : ARB_IMEM;
`else
  assign gnt = lock ? lock_id : d_ok ? ARB_DMEM : ARB_IMEM;
`endif
  assign mem_req_valid  = rst && (gnt == ARB_DMEM ? d_ok : i_ok);
  assign mem_req_addr   = gnt == ARB_DMEM ? dmem_req_addr : imem_req_addr;
  assign mem_req_wdata  = gnt == ARB_DMEM ? dmem_req_wdata : '0;
  assign mem_req_wmask  = gnt == ARB_DMEM ? dmem_req_wmask : '0;
  assign xfer           = mem_req_valid && mem_req_ready;
  assign imem_req_ready = xfer && gnt == ARB_IMEM;
  assign dmem_req_ready = xfer && gnt == ARB_DMEM;
  assign push           = xfer && (gnt == ARB_IMEM || !d_wr);
  // Discarded heads and orphan responses are always sunk so memory never stalls on them.
  assign mem_rsp_ready  = rst && (!head_valid || head.discard ||
                                  (head.id == ARB_IMEM ? imem_rsp_ready : dmem_rsp_ready));
  assign rsp_live       = rst && mem_rsp_valid && head_valid && !head.discard;
  assign imem_rsp_valid = rsp_live && head.id == ARB_IMEM;
  assign dmem_rsp_valid = rsp_live && head.id == ARB_DMEM;
  assign imem_rsp_data  = mem_rsp_data;
  assign dmem_rsp_data  = mem_rsp_data;
  assign pop            = mem_rsp_valid && mem_rsp_ready && head_valid;
  ama_riscv_arb_idq #(.DEPTH(OUTST)) u_idq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_id   (gnt),
    .pop       (pop),
    .flush     (flush_imem),
    .flush_id  (ARB_IMEM),
    .head      (head),
    .head_valid(head_valid),
    .full      (full),
    .empty     (empty)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock          <= 1'b0;
      lock_id       <= ARB_IMEM;
      err_unexp_rsp <= 1'b0;
    end else begin
      lock          <= mem_req_valid && !mem_req_ready;
      lock_id       <= gnt;
      err_unexp_rsp <= err_unexp_rsp | (mem_rsp_valid && empty && !push);
    end
  end
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant <= ARB_IMEM;
    else if (xfer) last_grant <= gnt;
  end
`endif
endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// tb_ama_riscv_mem_arb: table-driven directed vectors for the memory arbiter (default build, OUTST=2).
module tb_ama_riscv_mem_arb;
  logic        clk = 1'b0, rst = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid, dmem_rsp_ready;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_data;
  logic [3:0]  dmem_req_wmask, mem_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic        flush_imem, err_unexp_rsp;
  int          errors = 0, checks = 0;

  ama_riscv_mem_arb #(.OUTST(2), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_ready(dmem_rsp_ready), .dmem_rsp_data(dmem_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .flush_imem(flush_imem), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da, dwd;
    logic [3:0]  dwm;
    logic        mrq, msv;
    logic [31:0] msd;
    logic        irr, drr, fl;
    logic [6:0]  ex;
    logic [31:0] ea;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic dv,
                              input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dwm,
                              input logic mrq, input logic msv, input logic [31:0] msd,
                              input logic irr, input logic drr, input logic fl,
                              input logic [6:0] ex, input logic [31:0] ea);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dwd = dwd; v.dwm = dwm;
    v.mrq = mrq; v.msv = msv; v.msd = msd; v.irr = irr; v.drr = drr; v.fl = fl;
    v.ex = ex; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [6:0] flags();
    return {imem_req_ready, dmem_req_ready, mem_req_valid, mem_rsp_ready,
            imem_rsp_valid, dmem_rsp_valid, err_unexp_rsp};
  endfunction

  task automatic apply(input vec_t v);
    imem_req_valid = v.iv;  imem_req_addr = v.ia;
    dmem_req_valid = v.dv;  dmem_req_addr = v.da; dmem_req_wdata = v.dwd; dmem_req_wmask = v.dwm;
    mem_req_ready  = v.mrq; mem_rsp_valid = v.msv; mem_rsp_data = v.msd;
    imem_rsp_ready = v.irr; dmem_rsp_ready = v.drr; flush_imem = v.fl;
  endtask

  // flag order: {irdy, drdy, mem_req_valid, mem_rsp_ready, irsp_valid, drsp_valid, err}
  initial begin
    vt[0]  = mk(0, 0,     0, 0,     0,          4'h0, 0, 0, 0,     0, 0, 0, 7'b0001000, 0);
    vt[1]  = mk(1, 'h100, 0, 0,     0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b1011000, 'h100);
    vt[2]  = mk(0, 0,     0, 0,     0,          4'h0, 0, 0, 0,     1, 1, 0, 7'b0001000, 0);
    vt[3]  = mk(0, 0,     0, 0,     0,          4'h0, 0, 1, 'h13,  1, 1, 0, 7'b0001100, 0);
    vt[4]  = mk(1, 'h104, 1, 'h400, 0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b0111000, 'h400);
    vt[5]  = mk(1, 'h104, 0, 0,     0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b1011000, 'h104);
    vt[6]  = mk(1, 'h108, 0, 0,     0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b0001000, 0);
    vt[7]  = mk(1, 'h108, 1, 'h500, 'hDEADBEEF, 4'hF, 1, 0, 0,     1, 1, 0, 7'b0111000, 'h500);
    vt[8]  = mk(1, 'h108, 0, 0,     0,          4'h0, 1, 1, 'h55,  1, 1, 0, 7'b0001010, 0);
    vt[9]  = mk(1, 'h108, 0, 0,     0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b1011000, 'h108);
    vt[10] = mk(1, 'h200, 0, 0,     0,          4'h0, 1, 1, 'hAA,  0, 1, 1, 7'b0001000, 0);
    vt[11] = mk(1, 'h200, 0, 0,     0,          4'h0, 1, 1, 'hBB,  0, 1, 1, 7'b1011000, 'h200);
    vt[12] = mk(0, 0,     0, 0,     0,          4'h0, 0, 1, 'hCC,  1, 1, 0, 7'b0001100, 0);
    vt[13] = mk(1, 'h204, 0, 0,     0,          4'h0, 0, 0, 0,     1, 1, 0, 7'b0011000, 'h204);
    vt[14] = mk(1, 'h204, 1, 'h600, 0,          4'h0, 0, 0, 0,     1, 1, 0, 7'b0011000, 'h204);
    vt[15] = mk(1, 'h204, 1, 'h600, 0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b1011000, 'h204);
    vt[16] = mk(0, 0,     1, 'h600, 0,          4'h0, 1, 0, 0,     1, 1, 0, 7'b0111000, 'h600);
    vt[17] = mk(0, 0,     0, 0,     0,          4'h0, 0, 1, 'h11,  1, 0, 0, 7'b0001100, 0);
    vt[18] = mk(0, 0,     0, 0,     0,          4'h0, 0, 1, 'h22,  1, 0, 0, 7'b0000010, 0);
    vt[19] = mk(0, 0,     0, 0,     0,          4'h0, 0, 1, 'h22,  1, 1, 0, 7'b0001010, 0);
    vt[20] = mk(0, 0,     0, 0,     0,          4'h0, 0, 1, 'h77,  1, 1, 0, 7'b0001000, 0);
    vt[21] = mk(0, 0,     0, 0,     0,          4'h0, 0, 0, 0,     1, 1, 0, 7'b0001001, 0);

    // Everything asserted while held in reset: every valid/ready output must stay low.
    apply(mk(1, 'h100, 1, 'h400, 0, 4'h0, 1, 1, 'h1, 1, 1, 0, 0, 0));
    #3;
    chk("reset_flags", 64'(flags()), 64'(0));
    @(negedge clk);
    apply(vt[0]);
    rst = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      apply(vt[k]);
      #2;
      chk($sformatf("v%0d_flags", k), 64'(flags()), 64'(vt[k].ex));
      if (vt[k].ex[4])
        chk($sformatf("v%0d_addr", k), {28'h0, mem_req_wmask, mem_req_addr}, {28'h0, vt[k].dwm, vt[k].ea});
      if (vt[k].dwm != 4'h0)
        chk($sformatf("v%0d_wdata", k), 64'(mem_req_wdata), 64'(vt[k].dwd));
      if (vt[k].ex[2])
        chk($sformatf("v%0d_idata", k), 64'(imem_rsp_data), 64'(vt[k].msd));
      if (vt[k].ex[1])
        chk($sformatf("v%0d_ddata", k), 64'(dmem_rsp_data), 64'(vt[k].msd));
    end

    // Sticky error holds across idle cycles and only clears on reset.
    @(negedge clk);
    apply(vt[0]);
    #2;
    chk("err_sticky", 64'(err_unexp_rsp), 64'(1));
    rst = 1'b0;
    #1;
    chk("err_cleared", 64'(err_unexp_rsp), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("post_reset_flags", 64'(flags()), 64'(7'b0001000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
